// File: rtl/fetch_queue.sv
// fetch_queue -- instruction queue between the IF-stage PC block and ID.
//
// Captures (pc, inst) pairs from the fetch side, buffers up to DEPTH of them
// in a circular buffer and hands them to ID in order. Back-pressures the PC
// block through fetch_stall, clears on an exception flush and trims
// wrong-path entries on a taken branch while keeping the MIPS delay slot.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an incoming pair on an empty queue is presented to ID in
//   the same cycle and is consumed without being written if ID takes it.
//
// Handshake: ID-side transfer happens on a rising edge where
//   id_valid && id_ready. Fetch side has no ready; a pair offered while
//   fetch_stall is high is dropped and the PC block re-presents it.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   flush        exception flush, empties the queue at the next edge
//   redirect     taken branch resolved by ID, only together with a pop
//   in_valid     fetch pair valid (rom_en)
//   in_pc        fetch-stage PC
//   in_inst      ROM data for in_pc
//   fetch_stall  queue full, to stall_pc
//   id_ready     ID accepts the head entry
//   id_valid     head entry valid
//   id_pc        head PC (0 when not valid)
//   id_inst      head instruction (0 when not valid)
//   count        occupancy, 0..DEPTH
module fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       redirect,
  input  logic                       in_valid,
  input  logic [ADDR_WIDTH-1:0]      in_pc,
  input  logic [DATA_WIDTH-1:0]      in_inst,
  output logic                       fetch_stall,
  input  logic                       id_ready,
  output logic                       id_valid,
  output logic [ADDR_WIDTH-1:0]      id_pc,
  output logic [DATA_WIDTH-1:0]      id_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q;

  logic stored_valid;
  logic bypass;
  logic bypass_take;
  logic pop;
  logic push;
  logic redirect_cut;

  assign stored_valid = (count_q != '0);
  assign fetch_stall  = (count_q == CW'(DEPTH));
  assign count        = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = ~stored_valid & in_valid & ~flush & ~redirect;
`else
  assign bypass = 1'b0;
`endif

  assign bypass_take = bypass & id_ready;
  assign pop         = stored_valid & id_ready;

  // Taken branch with entries left behind the delay slot: keep only the
  // delay slot and discard both the younger entries and the incoming pair.
  // With nothing behind the branch, the incoming pair is the delay slot and
  // goes through the normal push path.
  assign redirect_cut = redirect & pop & ~flush & (count_q >= CW'(2));

  assign push = in_valid & ~fetch_stall & ~flush & ~redirect_cut & ~bypass_take;

  // Outputs are forced to zero when nothing valid is presented so stale or
  // uninitialised storage never leaks out.
  always_comb begin
    id_valid = stored_valid | bypass;
    id_pc    = '0;
    id_inst  = '0;
    if (stored_valid) begin
      id_pc   = pc_mem[rd_ptr];
      id_inst = inst_mem[rd_ptr];
    end else if (bypass) begin
      id_pc   = in_pc;
      id_inst = in_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (redirect_cut) begin
      rd_ptr  <= rd_ptr + PW'(1);
      wr_ptr  <= rd_ptr + PW'(2);
      count_q <= CW'(1);
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- directed bench for fetch_queue (default build, DEPTH=4).
//
// A table of per-cycle records gives the inputs applied after a falling edge
// and the outputs expected before the next rising edge. Hand-written
// sequences cover pointer wrap (with an expected-value queue) and an
// asynchronous reset in the middle of a stream.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] B = 32'hBFC0_0000;
  localparam logic [31:0] T = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst;
  logic        fetch_stall;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction word is derived from the PC so id_inst is checkable too.
  assign in_inst = ~in_pc;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .redirect    (redirect),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .fetch_stall (fetch_stall),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .count       (count)
  );

  // ---------------- clock / timeout ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  typedef struct {
    logic        flush;
    logic        redirect;
    logic        in_valid;
    logic [31:0] in_pc;
    logic        id_ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [2:0]  exp_count;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic f, logic r, logic v, logic [31:0] pc,
                              logic rdy, logic ev, logic [31:0] epc,
                              int ecnt, logic est);
    vec_t t;
    t.flush     = f;
    t.redirect  = r;
    t.in_valid  = v;
    t.in_pc     = pc;
    t.id_ready  = rdy;
    t.exp_valid = ev;
    t.exp_pc    = epc;
    t.exp_count = 3'(ecnt);
    t.exp_stall = est;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Protocol / range monitors evaluated every driven cycle.
  task automatic monitor();
    n_checks++;
    if (count > 3'(DEPTH)) begin
      n_fail++;
      $display("FAIL count_range: got %0d, expected <= %0d", count, DEPTH);
    end
    if (redirect) begin
      n_checks++;
      if (!(id_valid && id_ready)) begin
        n_fail++;
        $display("FAIL redirect_without_pop: id_valid=%b id_ready=%b, expected both 1",
                 id_valid, id_ready);
      end
    end
  endtask

  // Apply one cycle of inputs after the falling edge, settle before checks.
  task automatic drive(input logic f, input logic r, input logic v,
                       input logic [31:0] pc, input logic rdy);
    @(negedge clk);
    flush    = f;
    redirect = r;
    in_valid = v;
    in_pc    = pc;
    id_ready = rdy;
    #1;
    monitor();
  endtask

  // ---------------- scoreboard for hand-written sequences ----------------
  logic [31:0] exp_q[$];

  task automatic check_model(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, "_valid"}, 32'(id_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk({tag, "_pc"},   id_pc,   exp_q[0]);
      chk({tag, "_inst"}, id_inst, ~exp_q[0]);
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    logic [31:0] pc;

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(id_valid), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_stall", 32'(fetch_stall), 32'd0);
    chk("reset_pc", id_pc, 32'd0);
    chk("reset_inst", id_inst, 32'd0);
    rst = 1'b1;

    //           flush redir valid pc      rdy  ev  epc     cnt stall
    // Streaming with ID always ready: one cycle latency, count <= 1
    vecs.push_back(mk(0, 0, 1, B+32'h00, 1, 0, 32'h0,   0, 0));
    vecs.push_back(mk(0, 0, 1, B+32'h04, 1, 1, B+32'h00, 1, 0));
    vecs.push_back(mk(0, 0, 1, B+32'h08, 1, 1, B+32'h04, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 1, B+32'h08, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 0, 32'h0,   0, 0));
    // Fill to full, fifth pair blocked and re-presented, no duplicate
    vecs.push_back(mk(0, 0, 1, B+32'h00, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(0, 0, 1, B+32'h04, 0, 1, B+32'h00, 1, 0));
    vecs.push_back(mk(0, 0, 1, B+32'h08, 0, 1, B+32'h00, 2, 0));
    vecs.push_back(mk(0, 0, 1, B+32'h0C, 0, 1, B+32'h00, 3, 0));
    vecs.push_back(mk(0, 0, 1, B+32'h10, 0, 1, B+32'h00, 4, 1));
    vecs.push_back(mk(0, 0, 1, B+32'h10, 1, 1, B+32'h00, 4, 1));
    vecs.push_back(mk(0, 0, 1, B+32'h10, 1, 1, B+32'h04, 3, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 1, B+32'h08, 3, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 1, B+32'h0C, 2, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 1, B+32'h10, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 0, 32'h0,   0, 0));
    // Redirect with entries behind the delay slot
    vecs.push_back(mk(0, 0, 1, B+32'h00, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(0, 0, 1, B+32'h04, 0, 1, B+32'h00, 1, 0));
    vecs.push_back(mk(0, 0, 1, B+32'h08, 0, 1, B+32'h00, 2, 0));
    vecs.push_back(mk(0, 1, 1, B+32'h0C, 1, 1, B+32'h00, 3, 0));
    vecs.push_back(mk(0, 0, 1, T,        0, 1, B+32'h04, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 1, B+32'h04, 2, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 1, T,        1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 0, 32'h0,   0, 0));
    // Redirect on a single entry: incoming pair is the delay slot
    vecs.push_back(mk(0, 0, 1, B+32'h00, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 1, B+32'h04, 1, 1, B+32'h00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    0, 1, B+32'h04, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 1, B+32'h04, 1, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    1, 0, 32'h0,   0, 0));
    // Flush wins over push and redirect
    vecs.push_back(mk(0, 0, 1, B+32'h00, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(0, 0, 1, B+32'h04, 0, 1, B+32'h00, 1, 0));
    vecs.push_back(mk(0, 0, 1, B+32'h08, 0, 1, B+32'h00, 2, 0));
    vecs.push_back(mk(1, 1, 1, B+32'h0C, 1, 1, B+32'h00, 3, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,    0, 0, 32'h0,   0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flush, vecs[i].redirect, vecs[i].in_valid, vecs[i].in_pc,
            vecs[i].id_ready);
      chk($sformatf("vec%0d_valid", i), 32'(id_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_pc", i), id_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_inst", i), id_inst,
          vecs[i].exp_valid ? ~vecs[i].exp_pc : 32'h0);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_stall", i), 32'(fetch_stall), 32'(vecs[i].exp_stall));
    end

    // Pointer wrap: fill 3, then simultaneous push/pop for 10 cycles, drain
    exp_q.delete();
    pc = 32'h0000_2000;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, pc, 0);
      check_model("wrap_fill");
      exp_q.push_back(pc);
      pc += 32'd4;
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, pc, 1);
      check_model("wrap_flow");
      exp_q.push_back(pc);
      void'(exp_q.pop_front());
      pc += 32'd4;
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 32'h0, 1);
      check_model("wrap_drain");
      void'(exp_q.pop_front());
    end
    drive(0, 0, 0, 32'h0, 0);
    check_model("wrap_empty");

    // Asynchronous reset mid-stream, between clock edges
    drive(0, 0, 1, 32'h0000_3000, 0);
    drive(0, 0, 1, 32'h0000_3004, 0);
    drive(0, 0, 0, 32'h0, 0);
    chk("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(id_valid), 32'd0);
    chk("async_rst_pc", id_pc, 32'd0);
    chk("async_rst_inst", id_inst, 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_stall", 32'(fetch_stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 32'h0000_4000, 0);
    chk("post_rst_count0", 32'(count), 32'd0);
    drive(0, 0, 0, 32'h0, 1);
    chk("post_rst_pc", id_pc, 32'h0000_4000);
    chk("post_rst_count1", 32'(count), 32'd1);
    drive(0, 0, 0, 32'h0, 0);
    chk("post_rst_empty", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
